// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants, tx state type and baud helper
// Defining UART_TX_PARITY_EN adds the PARITY state to the transmit state type.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;
`endif

  // A zero baud rate yields 0 instead of an elaboration-time divide by zero.
  function automatic int uart_cycles(input int clk_hz, input int baud);
    return (baud > 0) ? clk_hz / baud : 0;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, 0..UART_CYCLES-1, shared by tx and rx
module uart_baud_counter #(
  parameter int UART_CYCLES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic count,
  output logic end_of_cycle
);

  localparam int              CNT_W = (UART_CYCLES >= 2) ? $clog2(UART_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UART_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign end_of_cycle = (cnt == LAST);

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= end_of_cycle ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
// Defining UART_TX_PARITY_EN inserts an even parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int BAUD_RATE     = 0
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_areset,
  input  logic       s_axis_tvalid,
  input  logic [7:0] s_axis_tdata,
  output logic       s_axis_tready,
  output logic       tx_bit,
  output logic       tx_busy
);

  localparam int UART_CYCLES = uart_cycles(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int BIT_W       = $clog2(DATA_BITS);

  tx_state_t              state, state_d;
  logic                   hold_valid;
  logic [DATA_BITS-1:0]   hold_data;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
  logic                   tx_bit_d;
  logic                   load;
  logic                   end_of_cycle;
`ifdef UART_TX_PARITY_EN
  logic                   parity, parity_d;
`endif

  assign s_axis_tready = !hold_valid && !s_axis_areset;
  assign tx_busy       = (state != TX_IDLE) || hold_valid;

  uart_baud_counter #(
    .UART_CYCLES (UART_CYCLES)
  ) u_baud (
    .aclk         (s_axis_aclk),
    .areset       (s_axis_areset),
    .clear        (load),
    .count        (state != TX_IDLE),
    .end_of_cycle (end_of_cycle)
  );

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    load      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (hold_valid) begin
          state_d = TX_START;
          load    = 1'b1;
        end
      end
      TX_START: begin
        if (end_of_cycle) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (end_of_cycle) begin
          shift_d = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (end_of_cycle) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        // A held byte starts its START bit right after this stop bit.
        if (end_of_cycle) begin
          if (hold_valid) begin
            state_d = TX_START;
            load    = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (load) begin
      shift_d   = hold_data;
      bit_cnt_d = '0;
    end

`ifdef UART_TX_PARITY_EN
    parity_d = load ? ^hold_data : parity;
`endif

    // tx_bit is registered from the next state so the line changes with the state.
    case (state_d)
      TX_START:  tx_bit_d = START_BIT;
      TX_DATA:   tx_bit_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_bit_d = parity_d;
`endif
      default:   tx_bit_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state   <= TX_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx_bit  <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx_bit  <= tx_bit_d;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_d;
`endif
    end
  end

  // Load needs hold_valid and a handshake needs !hold_valid, so they never coincide.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      hold_valid <= 1'b1;
      hold_data  <= s_axis_tdata;
    end
  end

endmodule
